// File: rtl/idli_sqi_resp_pkg.sv
// Shared types for the SQI memory responder.
// Instruction codes, FSM states and link field lengths.
package idli_sqi_resp_pkg;

  typedef logic [3:0] sqi_data_t;

  typedef enum logic [7:0] {
    SQI_INSTR_WRITE = 8'h02,
    SQI_INSTR_READ  = 8'h03
  } sqi_instr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INSTR,
    S_ADDR,
    S_DUMMY,
    S_RD_DATA,
    S_WR_DATA,
    S_IGNORE
  } sqi_resp_state_t;

  localparam int SQI_ADDR_NIBBLES  = 6;
  localparam int SQI_DUMMY_NIBBLES = 2;

  // Cycle index of the last nibble of each field.
  localparam logic [3:0] SQI_ADDR_LAST =
    4'(1 + SQI_ADDR_NIBBLES);
  localparam logic [3:0] SQI_DUMMY_LAST =
    4'(1 + SQI_ADDR_NIBBLES + SQI_DUMMY_NIBBLES);

endpackage

// File: rtl/idli_sqi_resp_if.sv
// SQI link between initiator (master) and memory responder (slave).
// Signal names are from the responder's point of view.
interface idli_sqi_resp_if
  import idli_sqi_resp_pkg::*;
();

  logic      i_sqi_cs;
  sqi_data_t i_sqi_sio;
  sqi_data_t o_sqi_sio;
  logic      o_sqi_sio_oe;

  modport master (
    output i_sqi_cs,
    output i_sqi_sio,
    input  o_sqi_sio,
    input  o_sqi_sio_oe
  );

  modport slave (
    input  i_sqi_cs,
    input  i_sqi_sio,
    output o_sqi_sio,
    output o_sqi_sio_oe
  );

endinterface

// File: rtl/idli_sqi_resp_mem.sv
// Byte array behind the SQI responder: async read, sync write.
// Kept separate so an FPGA block RAM can be dropped in.
module idli_sqi_resp_mem #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/idli_sqi_resp.sv
// SQI SRAM responder: sequential READ/WRITE over a nibble link.
// Stands in for one external SQI memory.
module idli_sqi_resp
  import idli_sqi_resp_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  idli_sqi_resp_if.slave sqi
);

  sqi_resp_state_t   state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  sqi_data_t         hi_q, hi_d;
  logic              nib_q, nib_d;
  logic              rd_q, rd_d;
  sqi_data_t         sio_q, sio_d;
  logic              oe_q, oe_d;

  logic              we;
  logic [ADDR_W-1:0] raddr;
  logic [7:0]        rdata;
  logic [7:0]        instr;

  // Second nibble of a read byte prefetches the next byte.
  assign raddr = (state_q == S_RD_DATA && nib_q)
               ? ptr_q + 1'b1 : ptr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    hi_d    = hi_q;
    nib_d   = nib_q;
    rd_d    = rd_q;
    sio_d   = sio_q;
    oe_d    = oe_q;
    we      = 1'b0;
    instr   = {hi_q, sqi.i_sqi_sio};
    if (sqi.i_sqi_cs) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      nib_d   = 1'b0;
      sio_d   = '0;
      oe_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          hi_d    = sqi.i_sqi_sio;
          cnt_d   = 4'd1;
          state_d = S_INSTR;
        end
        S_INSTR: begin
          cnt_d   = 4'd2;
          rd_d    = (instr == SQI_INSTR_READ);
          state_d = (instr == SQI_INSTR_READ ||
                     instr == SQI_INSTR_WRITE)
                  ? S_ADDR : S_IGNORE;
        end
        S_ADDR: begin
          // Upper address bits shift out: wrap modulo DEPTH.
          ptr_d = ADDR_W'({ptr_q, sqi.i_sqi_sio});
          cnt_d = cnt_q + 4'd1;
          nib_d = 1'b0;
          if (cnt_q == SQI_ADDR_LAST) begin
            state_d = rd_q ? S_DUMMY : S_WR_DATA;
          end
        end
        S_DUMMY: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == SQI_DUMMY_LAST) begin
            sio_d   = rdata[7:4];
            oe_d    = 1'b1;
            nib_d   = 1'b0;
            state_d = S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (!nib_q) begin
            sio_d = rdata[3:0];
            nib_d = 1'b1;
          end else begin
            sio_d = rdata[7:4];
            ptr_d = ptr_q + 1'b1;
            nib_d = 1'b0;
          end
        end
        S_WR_DATA: begin
          if (!nib_q) begin
            hi_d  = sqi.i_sqi_sio;
            nib_d = 1'b1;
          end else begin
            we    = 1'b1;
            ptr_d = ptr_q + 1'b1;
            nib_d = 1'b0;
          end
        end
        S_IGNORE: begin
          state_d = S_IGNORE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      hi_q    <= '0;
      nib_q   <= 1'b0;
      rd_q    <= 1'b0;
      sio_q   <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      hi_q    <= hi_d;
      nib_q   <= nib_d;
      rd_q    <= rd_d;
      sio_q   <= sio_d;
      oe_q    <= oe_d;
    end
  end

  idli_sqi_resp_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (we),
    .i_waddr (ptr_q),
    .i_wdata ({hi_q, sqi.i_sqi_sio}),
    .i_raddr (raddr),
    .o_rdata (rdata)
  );

  assign sqi.o_sqi_sio    = sio_q;
  assign sqi.o_sqi_sio_oe = oe_q;

endmodule

// File: tb/tb_idli_sqi_resp.sv
// Bench for idli_sqi_resp: directed cases plus random traffic
// checked against a flat byte-array model of the SRAM.
module tb_idli_sqi_resp;
  import idli_sqi_resp_pkg::*;

  localparam int DEPTH = 1024;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  idli_sqi_resp_if sq ();

  idli_sqi_resp #(
    .DEPTH (DEPTH)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .sqi   (sq)
  );

  always #5 i_clk = ~i_clk;

  logic [7:0] model [DEPTH];
  logic [7:0] wq [$];
  logic [3:0] obs_sio;
  logic       obs_oe;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int aidx(input logic [23:0] a,
                              input int i);
    return (int'(a) + i) % DEPTH;
  endfunction

  // Observe the previous edge's outputs, then drive the next nibble.
  task automatic cyc(input logic cs, input logic [3:0] nib);
    @(negedge i_clk);
    obs_sio = sq.o_sqi_sio;
    obs_oe  = sq.o_sqi_sio_oe;
    sq.i_sqi_cs  = cs;
    sq.i_sqi_sio = nib;
  endtask

  task automatic cmd(input logic [7:0] ins,
                     input logic [23:0] a);
    cyc(1'b0, ins[7:4]);
    check("cmd_oe", obs_oe, 0);
    cyc(1'b0, ins[3:0]);
    check("cmd_oe", obs_oe, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, a[23-4*i -: 4]);
      check("cmd_oe", obs_oe, 0);
    end
  endtask

  task automatic do_write(input logic [23:0] a);
    cmd(8'h02, a);
    for (int i = 0; i < wq.size(); i++) begin
      cyc(1'b0, wq[i][7:4]);
      check("wr_oe", obs_oe, 0);
      cyc(1'b0, wq[i][3:0]);
      check("wr_oe", obs_oe, 0);
      model[aidx(a, i)] = wq[i];
    end
    cyc(1'b1, 4'h0);
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    cmd(8'h03, a);
    cyc(1'b0, 4'($urandom));
    check("dum_oe", obs_oe, 0);
    cyc(1'b0, 4'($urandom));
    check("dum_oe", obs_oe, 0);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 4'($urandom));
      check("rd_oe", obs_oe, 1);
      check("rd_hi", obs_sio, model[aidx(a, i)][7:4]);
      cyc(1'b0, 4'($urandom));
      check("rd_oe", obs_oe, 1);
      check("rd_lo", obs_sio, model[aidx(a, i)][3:0]);
    end
    cyc(1'b1, 4'h0);
  endtask

  task automatic do_unknown(input logic [7:0] ins);
    cmd(ins, 24'($urandom));
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 4'($urandom));
      check("unk_oe", obs_oe, 0);
    end
    cyc(1'b1, 4'h0);
    check("unk_oe", obs_oe, 0);
  endtask

  task automatic set_wq(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
  endtask

  logic [23:0] ra;
  logic [7:0]  ri;
  int          rn;

  initial begin
    sq.i_sqi_cs  = 1'b1;
    sq.i_sqi_sio = 4'h0;
    @(negedge i_clk);
    @(negedge i_clk);
    check("rst_oe", sq.o_sqi_sio_oe, 0);
    check("rst_sio", sq.o_sqi_sio, 0);
    i_rst = 1'b0;
    cyc(1'b1, 4'h0);

    // Fill the whole array so every later read is defined.
    set_wq(DEPTH);
    do_write(24'h000000);

    // Write then read back.
    wq = '{8'hA5, 8'h3C};
    do_write(24'h000010);
    do_read(24'h000010, 2);

    // Wrap at the top of the array.
    wq = '{8'h11, 8'h22};
    do_write(24'h0003FF);
    do_read(24'h0003FF, 2);
    do_read(24'h000000, 1);

    // Upper address bits are ignored.
    wq = '{8'h7E};
    do_write(24'hFFFC00);
    do_read(24'h000000, 1);

    // Write aborted after the high nibble.
    wq = '{8'h44};
    do_write(24'h000020);
    cmd(8'h02, 24'h000020);
    cyc(1'b0, 4'hB);
    cyc(1'b1, 4'h0);
    do_read(24'h000020, 1);

    // Unknown instruction, then a normal read.
    do_unknown(8'h05);
    do_read(24'h000010, 2);

    // Reset in the middle of a read.
    cmd(8'h03, 24'h000010);
    for (int i = 0; i < 5; i++) cyc(1'b0, 4'h0);
    check("pre_rst_oe", sq.o_sqi_sio_oe, 1);
    #2 i_rst = 1'b1;
    #1;
    check("mid_rst_oe", sq.o_sqi_sio_oe, 0);
    check("mid_rst_sio", sq.o_sqi_sio, 0);
    sq.i_sqi_cs = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 4'h0);
      check("post_rst_oe", obs_oe, 0);
      check("post_rst_sio", obs_sio, 0);
    end
    do_read(24'h000010, 2);

    // Random traffic.
    for (int t = 0; t < 80; t++) begin
      ra = 24'($urandom);
      rn = $urandom_range(1, 6);
      case ($urandom_range(0, 4))
        0: begin
          set_wq(rn);
          do_write(ra);
        end
        1: do_read(ra, rn);
        2: begin
          set_wq(rn);
          cmd(8'h02, ra);
          for (int i = 0; i < rn; i++) begin
            cyc(1'b0, wq[i][7:4]);
            cyc(1'b0, wq[i][3:0]);
            model[aidx(ra, i)] = wq[i];
          end
          cyc(1'b0, 4'($urandom));
          cyc(1'b1, 4'h0);
        end
        3: begin
          do ri = 8'($urandom);
          while (ri == 8'h02 || ri == 8'h03);
          do_unknown(ri);
        end
        default: begin
          cmd(8'h03, ra);
          for (int i = 0; i < rn; i++) cyc(1'b0, 4'h0);
          cyc(1'b1, 4'h0);
        end
      endcase
      do_read(ra, 6);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
